prbs_checker_parallel_fab: RTL and testbench

- Receive-side companion to the parallel fabric PRBS generator.
- Accepts one NBITS-wide word per valid cycle, self-synchronises to the x^POLY2 + x^(POLY2-POLY1) + 1 sequence, then tracks it with an internal reference LFSR.
- Reports lock, per-word error flag and saturating bit-error / word counters to SmartDebug probe registers in the IOD loopback flow.

---
 rtl/prbs_pkg.sv | 41 ++++
 rtl/prbs_checker_parallel_fab_popcount.sv | 20 ++
 rtl/prbs_checker_parallel_fab.sv | 171 +++++++++++++++++
 tb/tb_prbs_checker_parallel_fab.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: default polynomial/width, checker state encoding and
// the next-word function F used by both the fabric generator and checker.
package prbs_pkg;

  localparam int NBITS_DEF  = 8;
  localparam int POLY2_DEF  = 7;
  localparam int POLY1_DEF  = 1;
  localparam int PRBS_MAX_W = 64;
  localparam int SIDX_W     = $clog2(2 * PRBS_MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // F(w): seed the top POLY2 positions with the low bits of w, then fill the
  // word from the top down with s[i] = s[i+POLY2] ^ s[i+POLY2-POLY1].
  function automatic logic [PRBS_MAX_W-1:0] prbs_next(
    input logic [PRBS_MAX_W-1:0] word,
    input int                    nbits,
    input int                    poly2,
    input int                    poly1
  );
    logic [2*PRBS_MAX_W-1:0] s;
    logic [PRBS_MAX_W-1:0]   r;
    s = '0;
    r = '0;
    for (int j = 0; j < PRBS_MAX_W; j++) begin
      if (j < poly2) s[SIDX_W'(nbits + j)] = word[j];
    end
    for (int i = PRBS_MAX_W - 1; i >= 0; i--) begin
      if (i < nbits) begin
        s[i] = s[SIDX_W'(i + poly2)] ^ s[SIDX_W'(i + poly2 - poly1)];
        r[i] = s[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_checker_parallel_fab_popcount.sv
// Combinational population count of an NBITS-wide word.
//   data_i  : word to count
//   count_o : number of set bits
module prbs_popcount #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0]             data_i,
  output logic [$clog2(NBITS+1)-1:0]   count_o
);

  localparam int CW = $clog2(NBITS + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NBITS; i++) begin
      count_o = count_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/prbs_checker_parallel_fab.sv
// Parallel PRBS checker: self-synchronises to the fabric generator stream,
// then tracks it with a reference LFSR and reports lock, per-word errors and
// saturating bit-error / word counters.
//   clk_i, resetn_i           : clock, synchronous active-low reset
//   chk_en_i, clear_i         : enable (low = idle), counter clear / resync
//   data_valid_i, data_i      : received word strobe and data
//   lock_o, err_o, err_bits_o : lock status, error pulse, bit errors of last word
//   err_cnt_o, word_cnt_o     : accumulated bit errors, words checked while locked
module prbs_checker_parallel_fab
  import prbs_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int POLY2      = POLY2_DEF,
  parameter int POLY1      = POLY1_DEF,
  parameter int MSB_FIRST  = 0,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                         clk_i,
  input  logic                         resetn_i,
  input  logic                         chk_en_i,
  input  logic                         clear_i,
  input  logic                         data_valid_i,
  input  logic [NBITS-1:0]             data_i,
  output logic                         lock_o,
  output logic                         err_o,
  output logic [$clog2(NBITS+1)-1:0]   err_bits_o,
  output logic [CNT_W-1:0]             err_cnt_o,
  output logic [CNT_W-1:0]             word_cnt_o
);

  localparam int EBW = $clog2(NBITS + 1);

  function automatic logic [NBITS-1:0] f_next(input logic [NBITS-1:0] w);
    return NBITS'(prbs_next(PRBS_MAX_W'(w), NBITS, POLY2, POLY1));
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // ---- stage p0: received word alignment and comparison ----
  logic [NBITS-1:0] rx_p0;
  logic             vld_p0;
  logic [EBW-1:0]   bits_p0;

  chk_state_t       state_p1, state_nx;
  logic [NBITS-1:0] prev_p1, prev_nx;
  logic [NBITS-1:0] ref_p1, ref_nx;
  logic [7:0]       good_p1, good_nx, good_inc;
  logic [7:0]       bad_p1, bad_nx, bad_inc;
  logic             err_p1, err_nx;
  logic [EBW-1:0]   err_bits_p1, err_bits_nx;
  logic [CNT_W-1:0] err_cnt_p1, err_cnt_nx;
  logic [CNT_W-1:0] word_cnt_p1, word_cnt_nx;
  logic             match;

  generate
    if (MSB_FIRST != 0) begin : g_rev
      always_comb begin
        for (int i = 0; i < NBITS; i++) rx_p0[i] = data_i[NBITS-1-i];
      end
    end else begin : g_fwd
      assign rx_p0 = data_i;
    end
  endgenerate

  assign vld_p0 = data_valid_i;

  prbs_popcount #(.NBITS(NBITS)) u_popcount (
    .data_i  (rx_p0 ^ ref_p1),
    .count_o (bits_p0)
  );

  always_comb begin
    state_nx    = state_p1;
    prev_nx     = prev_p1;
    ref_nx      = ref_p1;
    good_nx     = good_p1;
    bad_nx      = bad_p1;
    err_nx      = 1'b0;
    err_bits_nx = err_bits_p1;
    err_cnt_nx  = err_cnt_p1;
    word_cnt_nx = word_cnt_p1;
    match       = 1'b0;
    good_inc    = good_p1 + 8'd1;
    bad_inc     = bad_p1 + 8'd1;

    if (!chk_en_i) begin
      state_nx = ST_IDLE;
    end else if (clear_i) begin
      state_nx    = ST_SEARCH;
      good_nx     = '0;
      bad_nx      = '0;
      err_cnt_nx  = '0;
      word_cnt_nx = '0;
    end else begin
      case (state_p1)
        ST_IDLE: state_nx = ST_SEARCH;
        ST_SEARCH: begin
          if (vld_p0) begin
            match   = (rx_p0 == f_next(prev_p1)) && (rx_p0 != '0) && (prev_p1 != '0);
            good_nx = match ? good_inc : 8'd0;
            prev_nx = rx_p0;
            if (match && (good_inc == 8'(LOCK_CNT))) begin
              state_nx = ST_LOCKED;
              ref_nx   = f_next(rx_p0);
              bad_nx   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (vld_p0) begin
            ref_nx      = f_next(ref_p1);
            word_cnt_nx = sat_add(word_cnt_p1, CNT_W'(1));
            err_bits_nx = bits_p0;
            if (bits_p0 != '0) begin
              err_nx     = 1'b1;
              err_cnt_nx = sat_add(err_cnt_p1, CNT_W'(bits_p0));
              bad_nx     = bad_inc;
              if (bad_inc == 8'(UNLOCK_CNT)) begin
                state_nx = ST_SEARCH;
                good_nx  = '0;
                prev_nx  = rx_p0;
              end
            end else begin
              bad_nx = '0;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: registered checker state and outputs ----
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_p1    <= ST_IDLE;
      prev_p1     <= '0;
      ref_p1      <= '0;
      good_p1     <= '0;
      bad_p1      <= '0;
      err_p1      <= 1'b0;
      err_bits_p1 <= '0;
      err_cnt_p1  <= '0;
      word_cnt_p1 <= '0;
    end else begin
      state_p1    <= state_nx;
      prev_p1     <= prev_nx;
      ref_p1      <= ref_nx;
      good_p1     <= good_nx;
      bad_p1      <= bad_nx;
      err_p1      <= err_nx;
      err_bits_p1 <= err_bits_nx;
      err_cnt_p1  <= err_cnt_nx;
      word_cnt_p1 <= word_cnt_nx;
    end
  end

  assign lock_o     = (state_p1 == ST_LOCKED);
  assign err_o      = err_p1;
  assign err_bits_o = err_bits_p1;
  assign err_cnt_o  = err_cnt_p1;
  assign word_cnt_o = word_cnt_p1;

endmodule

// File: tb/tb_prbs_checker_parallel_fab.sv
module tb_prbs_checker_parallel_fab;

  localparam int NB   = 8;
  localparam int CW   = 10;
  localparam int LCK  = 16;
  localparam int ULK  = 4;
  localparam int MAXC = (1 << CW) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          chk_en = 1'b0;
  logic          clear = 1'b0;
  logic          data_valid = 1'b0;
  logic [NB-1:0] data = '0;
  logic          lock_o, err_o;
  logic [3:0]    err_bits_o;
  logic [CW-1:0] err_cnt_o, word_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  prbs_checker_parallel_fab #(
    .NBITS(NB), .POLY2(7), .POLY1(1), .MSB_FIRST(0),
    .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .CNT_W(CW)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .chk_en_i     (chk_en),
    .clear_i      (clear),
    .data_valid_i (data_valid),
    .data_i       (data),
    .lock_o       (lock_o),
    .err_o        (err_o),
    .err_bits_o   (err_bits_o),
    .err_cnt_o    (err_cnt_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk = ~clk;

  // Serial view of the sequence: x[n] = x[n-7] ^ x[n-6]; a word is 8
  // consecutive bits with the earliest bit in the MSB.
  function automatic logic [NB-1:0] tb_next(input logic [NB-1:0] w);
    bit q[$];
    logic [NB-1:0] r;
    for (int k = 6; k >= 0; k--) q.push_back(w[k]);
    for (int k = 0; k < NB; k++) q.push_back(q[$-6] ^ q[$-5]);
    r = '0;
    for (int k = 0; k < NB; k++) r[NB-1-k] = q[7+k];
    return r;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference
  int      st = M_IDLE;
  int      good = 0, bad = 0, nb = 0;
  logic [NB-1:0] prev = '0, rf = '0;
  int      m_ecnt = 0, m_wcnt = 0, m_bits = 0;
  bit      m_err = 0, m_lock = 0, started = 0;

  always @(posedge clk) begin
    started = 1;
    if (!resetn) begin
      st = M_IDLE; prev = '0; rf = '0; good = 0; bad = 0;
      m_err = 0; m_bits = 0; m_ecnt = 0; m_wcnt = 0;
    end else if (!chk_en) begin
      st = M_IDLE; m_err = 0;
    end else if (clear) begin
      m_ecnt = 0; m_wcnt = 0; good = 0; bad = 0; st = M_SEARCH; m_err = 0;
    end else begin
      m_err = 0;
      if (st == M_IDLE) st = M_SEARCH;
      else if (data_valid) begin
        if (st == M_SEARCH) begin
          if (data == tb_next(prev) && data != 0 && prev != 0) good++;
          else good = 0;
          prev = data;
          if (good == LCK) begin st = M_LOCKED; rf = tb_next(data); bad = 0; end
        end else begin
          nb = $countones(data ^ rf);
          m_bits = nb;
          rf = tb_next(rf);
          m_wcnt = (m_wcnt + 1 > MAXC) ? MAXC : m_wcnt + 1;
          if (nb != 0) begin
            m_err = 1;
            m_ecnt = (m_ecnt + nb > MAXC) ? MAXC : m_ecnt + nb;
            bad++;
            if (bad == ULK) begin st = M_SEARCH; good = 0; prev = data; end
          end else bad = 0;
        end
      end
    end
    m_lock = (st == M_LOCKED);
  end

  always @(negedge clk) begin
    if (started) begin
      check("lock_o", lock_o, m_lock);
      check("err_o", err_o, m_err);
      check("err_bits_o", err_bits_o, m_bits);
      check("err_cnt_o", err_cnt_o, m_ecnt);
      check("word_cnt_o", word_cnt_o, m_wcnt);
    end
  end

  task automatic cyc(input logic v, input logic [NB-1:0] d);
    data_valid = v;
    data = d;
    @(posedge clk);
    #1;
  endtask

  logic [NB-1:0] g, d;
  int r, k;

  initial begin
    check("F_FF", tb_next(8'hFF), 8'h02);
    check("F_02", tb_next(8'h02), 8'h0C);
    check("F_A5", tb_next(8'hA5), 8'hDC);

    repeat (3) cyc(0, '0);
    check("rst_lock", lock_o, 0);
    check("rst_err", err_o, 0);
    check("rst_bits", err_bits_o, 0);
    check("rst_ecnt", err_cnt_o, 0);
    check("rst_wcnt", word_cnt_o, 0);

    // Initial lock on a clean stream
    resetn = 1; chk_en = 1;
    cyc(0, '0);
    g = 8'hFF;
    for (int i = 1; i <= 17; i++) begin
      cyc(1, g); g = tb_next(g);
      if (i == 16) check("lock_before_16th_match", lock_o, 0);
      if (i == 17) check("lock_after_16th_match", lock_o, 1);
    end
    for (int i = 0; i < 20; i++) begin cyc(1, g); g = tb_next(g); end
    check("wcnt_20", word_cnt_o, 20);
    check("ecnt_clean", err_cnt_o, 0);

    // Two flipped bits in one word
    cyc(1, g ^ 8'h21); g = tb_next(g);
    check("flip_err", err_o, 1);
    check("flip_bits", err_bits_o, 2);
    check("flip_ecnt", err_cnt_o, 2);
    check("flip_lock", lock_o, 1);
    cyc(1, g); g = tb_next(g);
    check("after_flip_err", err_o, 0);
    check("after_flip_ecnt", err_cnt_o, 2);

    // Idle pattern drops lock after 4 errored words
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'hA5); g = tb_next(g);
      check("a5_err", err_o, 1);
      check("a5_lock", lock_o, (i < 3) ? 1 : 0);
    end
    for (int i = 1; i <= 17; i++) begin cyc(1, g); g = tb_next(g); end
    check("relock", lock_o, 1);

    // Accumulate exactly 37 bit errors, then clear
    while (m_ecnt < 37) begin
      k = 37 - m_ecnt;
      if (k > 8) k = 8;
      cyc(1, g ^ 8'((1 << k) - 1)); g = tb_next(g);
      cyc(1, g); g = tb_next(g);
    end
    check("ecnt_37", err_cnt_o, 37);
    check("lock_37", lock_o, 1);
    clear = 1; cyc(1, g); clear = 0;
    check("clr_ecnt", err_cnt_o, 0);
    check("clr_wcnt", word_cnt_o, 0);
    check("clr_lock", lock_o, 0);

    // Zeros and constant idle pattern never lock
    for (int i = 0; i < 30; i++) begin cyc(1, 8'h00); check("zero_nolock", lock_o, 0); end
    for (int i = 0; i < 30; i++) begin cyc(1, 8'hA5); check("a5_nolock", lock_o, 0); end

    // Valid toggling
    g = 8'hFF;
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 8'($urandom));
      cyc(1, g); g = tb_next(g);
      if (i == 16) check("tog_lock_before", lock_o, 0);
      if (i == 17) check("tog_lock_after", lock_o, 1);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'($urandom));
      cyc(1, g); g = tb_next(g);
    end
    check("tog_wcnt", word_cnt_o, 10);

    // Saturation of both counters
    for (int i = 0; i < 600; i++) begin
      cyc(1, g ^ 8'hFF); g = tb_next(g);
      cyc(1, g); g = tb_next(g);
    end
    check("sat_ecnt", err_cnt_o, MAXC);
    check("sat_wcnt", word_cnt_o, MAXC);
    check("sat_lock", lock_o, 1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        clear = 1; cyc(1, g); clear = 0;
      end else if (r < 6) begin
        chk_en = 0;
        repeat ($urandom_range(1, 3)) cyc(1, g);
        chk_en = 1;
      end else if (r < 10) begin
        repeat (5) cyc(1, 8'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        cyc(0, 8'($urandom));
      end else begin
        d = g;
        if ($urandom_range(0, 15) == 0) d = d ^ 8'($urandom);
        cyc(1, d); g = tb_next(g);
      end
    end

    // Reset mid-stream
    resetn = 0;
    cyc(1, g);
    check("mid_rst_lock", lock_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_bits", err_bits_o, 0);
    check("mid_rst_ecnt", err_cnt_o, 0);
    check("mid_rst_wcnt", word_cnt_o, 0);
    resetn = 1;
    cyc(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
